// File: rtl/dmem_pkg.sv
// Shared codes, state encoding and request checker for the data-memory access unit.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Request checks in priority order: bad width code, then alignment, then range.
  function automatic logic [1:0] check_req(input logic       write,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off,
                                           input logic       in_range);
    logic illegal;
    logic misaligned;
    if (write) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else       illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && off[0]) ||
                 ((funct3 == F3_W) && (off != 2'b00));
    if (illegal)         return ERR_FUNCT3;
    else if (misaligned) return ERR_MISALIGN;
    else if (!in_range)  return ERR_RANGE;
    else                 return ERR_OK;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/lane replication and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_mask,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_shifted = load_word >> {off, 3'b000};
  assign half_shifted = load_word >> {off[1], 4'b0000};
  assign byte_lane    = byte_shifted[7:0];
  assign half_lane    = half_shifted[15:0];

  // Store side: only B/H/W reach here, so the low two funct3 bits pick the width.
  always_comb begin
    store_mask  = 4'b0000;
    store_lanes = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        store_mask  = 4'b0001 << off;
        store_lanes = {4{store_data[7:0]}};
      end
      2'b01: begin
        store_mask  = off[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
      end
      default: begin
        store_mask  = 4'b1111;
        store_lanes = store_data;
      end
    endcase
  end

  // Load side: pick the lane and sign- or zero-extend it.
  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store initiator for a word-addressed, byte-masked, 1-cycle synchronous data memory.
//
// state | meaning
// IDLE  | ready for a request; checks it on acceptance
// ISSUE | single cycle driving the memory read or write enable
// WAIT  | memory read data arriving; extracted into the response
// RESP  | response held until the consumer takes it
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_error,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_write_mask,
  input  logic [31:0]           mem_read_data
);

  state_t                state_q, state_d;
  logic [31:0]           offs;
  logic                  in_range;
  logic [1:0]            req_err;
  logic                  accept;

  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           rdata_q;
  logic [1:0]            err_q;

  logic [3:0]            lane_mask;
  logic [31:0]           lane_wdata;
  logic [31:0]           lane_rdata;

  // Unsigned subtract: addresses below the base wrap high and fall out of range.
  assign offs     = req_addr - DMEM_BASE;
  assign in_range = ({1'b0, offs} < (33'd4 << ADDR_WIDTH));
  assign req_err  = check_req(req_write, req_funct3, req_addr[1:0], in_range);
  assign accept   = (state_q == IDLE) && req_valid;

  dmem_lane_align u_lane_align (
    .funct3      (funct3_q),
    .off         (off_q),
    .store_data  (wdata_q),
    .load_word   (mem_read_data),
    .store_mask  (lane_mask),
    .store_lanes (lane_wdata),
    .load_data   (lane_rdata)
  );

  // State register; async reset drops any in-flight access without a response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and the state-decoded handshake / memory enables.
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_err != ERR_OK) ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_read_enable  = !write_q;
        mem_write_enable = write_q;
        state_d          = write_q ? RESP : WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on acceptance and load result capture at the end of WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      addr_q   <= '0;
      rdata_q  <= 32'h0;
      err_q    <= ERR_OK;
    end else if (accept) begin
      write_q  <= req_write;
      funct3_q <= req_funct3;
      off_q    <= req_addr[1:0];
      wdata_q  <= req_wdata;
      rdata_q  <= 32'h0;
      err_q    <= req_err;
      if (req_err == ERR_OK) addr_q <= offs[ADDR_WIDTH+1:2];
    end else if (state_q == WAIT) begin
      rdata_q <= lane_rdata;
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_mask = mem_write_enable ? lane_mask  : 4'b0000;
  assign mem_write_data = mem_write_enable ? lane_wdata : 32'h0;
  assign resp_rdata     = rdata_q;
  assign resp_error     = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized
// traffic checked against a byte-array reference memory.
module tb_dmem_access_unit;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_error;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [3:0]    mem_write_mask;
  logic [31:0]   mem_read_data = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_access_unit #(.ADDR_WIDTH(AW), .DMEM_BASE(BASE)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_mask   (mem_write_mask),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Environment memory: 1-cycle synchronous, byte-masked writes.
  logic [31:0] env_mem [0:(1<<AW)-1];
  logic [31:0] env_merged;
  always_comb begin
    env_merged = env_mem[mem_address];
    for (int i = 0; i < 4; i++)
      if (mem_write_mask[i]) env_merged[8*i +: 8] = mem_write_data[8*i +: 8];
  end
  always @(posedge clk) begin
    if (mem_write_enable) env_mem[mem_address] <= env_merged;
    if (mem_read_enable)  mem_read_data <= env_mem[mem_address];
  end

  // Reference model: flat byte memory, little-endian.
  logic [7:0] ref_mem [0:(4<<AW)-1];

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] exp_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    int   sz;
    logic [31:0] rel;
    if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2'b11;
    sz = size_of(f3);
    if ((a % sz) != 0) return 2'b01;
    rel = a - BASE;
    if (rel >= (32'd4 << AW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int          sz;
    int          idx;
    logic [31:0] v;
    sz  = size_of(f3);
    idx = int'(a - BASE);
    v   = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[idx+i]) << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int         o;
    m = 4'b0000;
    o = int'(a[1:0]);
    for (int i = 0; i < size_of(f3); i++) m[o+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [2:0] f3, input logic [31:0] wd);
    if (size_of(f3) == 1) return {4{wd[7:0]}};
    if (size_of(f3) == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int idx;
    idx = int'(a - BASE);
    for (int i = 0; i < size_of(f3); i++) ref_mem[idx+i] = wd[8*i +: 8];
  endtask

  // Observations of the last request.
  logic [31:0]   o_rd, o_data;
  logic [1:0]    o_er;
  logic [3:0]    o_mask;
  logic [AW-1:0] o_maddr;
  logic          o_stable, o_to;
  int            o_lat, o_nwe, o_nre;

  // Drive one request and record what the DUT does; hold = cycles with resp_ready low.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
    int guard;
    o_rd = 32'h0; o_er = 2'b00; o_mask = 4'h0; o_data = 32'h0; o_maddr = '0;
    o_stable = 1'b1; o_to = 1'b0; o_lat = 0; o_nwe = 0; o_nre = 0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) o_to = 1'b1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 1;
    forever begin
      if (mem_write_enable) begin
        o_nwe++; o_mask = mem_write_mask; o_data = mem_write_data; o_maddr = mem_address;
      end
      if (mem_read_enable) begin
        o_nre++; o_maddr = mem_address;
      end
      if (resp_valid || o_lat >= 20) break;
      @(posedge clk); #1;
      o_lat++;
    end
    if (!resp_valid) o_to = 1'b1;
    o_rd = resp_rdata;
    o_er = resp_error;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== o_rd || resp_error !== o_er ||
          req_ready !== 1'b0 || mem_read_enable || mem_write_enable) o_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) o_stable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 2'b00 ||
        mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || mem_write_mask !== 4'h0 ||
        mem_write_data !== 32'h0 || mem_address !== '0) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b rv=%b rd=%h er=%b re=%b we=%b m=%h d=%h a=%h want rdy=1 rest 0",
               req_ready, resp_valid, resp_rdata, resp_error, mem_read_enable, mem_write_enable,
               mem_write_mask, mem_write_data, mem_address);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    run_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0);
    ref_store(3'b010, 32'h010, 32'hDEADBEEF);
    n_cmp++;
    if (o_nwe !== 1 || o_nre !== 0 || o_maddr !== 10'd4 || o_mask !== 4'b1111 || o_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL sw_issue got we=%0d re=%0d a=%0d m=%b d=%h want we=1 re=0 a=4 m=1111 d=deadbeef",
               o_nwe, o_nre, o_maddr, o_mask, o_data);
    end
    n_cmp++;
    if (o_er !== 2'b00 || o_lat !== 2 || o_to) begin
      n_bad++;
      $display("FAIL sw_resp got err=%b lat=%0d to=%b want err=00 lat=2 to=0", o_er, o_lat, o_to);
    end
  endtask

  task automatic test_load_extend();
    run_req(1'b0, 3'b000, 32'h013, 32'h0, 0);
    n_cmp++;
    if (o_rd !== 32'hFFFFFFDE || o_er !== 2'b00 || o_lat !== 3) begin
      n_bad++;
      $display("FAIL lb got rd=%h err=%b lat=%0d want ffffffde 00 3", o_rd, o_er, o_lat);
    end
    run_req(1'b0, 3'b100, 32'h013, 32'h0, 0);
    n_cmp++;
    if (o_rd !== 32'h000000DE || o_er !== 2'b00) begin
      n_bad++;
      $display("FAIL lbu got rd=%h err=%b want 000000de 00", o_rd, o_er);
    end
    run_req(1'b0, 3'b001, 32'h010, 32'h0, 0);
    n_cmp++;
    if (o_rd !== 32'hFFFFBEEF || o_er !== 2'b00 || o_nre !== 1 || o_nwe !== 0) begin
      n_bad++;
      $display("FAIL lh got rd=%h err=%b re=%0d we=%0d want ffffbeef 00 1 0", o_rd, o_er, o_nre, o_nwe);
    end
  endtask

  task automatic test_store_byte();
    run_req(1'b1, 3'b000, 32'h011, 32'h12345677, 0);
    ref_store(3'b000, 32'h011, 32'h12345677);
    n_cmp++;
    if (o_mask !== 4'b0010 || o_data !== 32'h77777777 || o_nwe !== 1) begin
      n_bad++;
      $display("FAIL sb_issue got m=%b d=%h we=%0d want 0010 77777777 1", o_mask, o_data, o_nwe);
    end
    run_req(1'b0, 3'b010, 32'h010, 32'h0, 0);
    n_cmp++;
    if (o_rd !== 32'hDEAD77EF) begin
      n_bad++;
      $display("FAIL lw_after_sb got %h want dead77ef", o_rd);
    end
  endtask

  task automatic test_errors();
    run_req(1'b0, 3'b001, 32'h003, 32'h0, 0);
    n_cmp++;
    if (o_er !== 2'b01 || o_nre !== 0 || o_nwe !== 0 || o_rd !== 32'h0 || o_lat !== 1) begin
      n_bad++;
      $display("FAIL err_misalign got err=%b re=%0d we=%0d rd=%h lat=%0d want 01 0 0 0 1",
               o_er, o_nre, o_nwe, o_rd, o_lat);
    end
    run_req(1'b0, 3'b010, 32'h1000, 32'h0, 0);
    n_cmp++;
    if (o_er !== 2'b10 || o_nre !== 0 || o_nwe !== 0) begin
      n_bad++;
      $display("FAIL err_range got err=%b re=%0d we=%0d want 10 0 0", o_er, o_nre, o_nwe);
    end
    run_req(1'b0, 3'b011, 32'h010, 32'h0, 0);
    n_cmp++;
    if (o_er !== 2'b11 || o_nre !== 0 || o_nwe !== 0) begin
      n_bad++;
      $display("FAIL err_funct3 got err=%b re=%0d we=%0d want 11 0 0", o_er, o_nre, o_nwe);
    end
    run_req(1'b0, 3'b010, 32'h0FFC, 32'h0, 0);
    n_cmp++;
    if (o_er !== 2'b00 || o_nre !== 1 || o_maddr !== 10'd1023) begin
      n_bad++;
      $display("FAIL last_word got err=%b re=%0d a=%0d want 00 1 1023", o_er, o_nre, o_maddr);
    end
  endtask

  task automatic test_backpressure();
    run_req(1'b0, 3'b010, 32'h010, 32'h0, 5);
    n_cmp++;
    if (o_stable !== 1'b1 || o_rd !== 32'hDEAD77EF || o_to) begin
      n_bad++;
      $display("FAIL backpressure got stable=%b rd=%h to=%b want 1 dead77ef 0", o_stable, o_rd, o_to);
    end
  endtask

  task automatic test_reset_mid();
    run_req(1'b1, 3'b010, 32'h020, 32'hCAFEF00D, 0);
    ref_store(3'b010, 32'h020, 32'hCAFEF00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h020; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_write_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_issue got we=%b want 1", mem_write_enable);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_write_enable !== 1'b0 || mem_write_mask !== 4'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset got we=%b m=%b rv=%b rdy=%b want 0 0000 0 1",
               mem_write_enable, mem_write_mask, resp_valid, req_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_no_resp got rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    run_req(1'b0, 3'b010, 32'h020, 32'h0, 0);
    n_cmp++;
    if (o_rd !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL mid_old_value got %h want cafef00d", o_rd);
    end
  endtask

  task automatic test_random();
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd;
    logic [1:0]  e_er;
    int          e_lat, sel;
    for (int t = 0; t < 250; t++) begin
      wr  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 127));
      else if (sel == 7) a = 32'h0FF8 + 32'($urandom_range(0, 15));
      else if (sel == 8) a = BASE - 32'($urandom_range(1, 8));
      else               a = $urandom;
      e_er  = exp_err(wr, f3, a);
      e_rd  = (e_er == 2'b00 && !wr) ? exp_load(f3, a) : 32'h0;
      e_lat = (e_er != 2'b00) ? 1 : (wr ? 2 : 3);
      run_req(wr, f3, a, wd, (t % 17 == 5) ? 2 : 0);
      n_cmp++;
      if (o_er !== e_er || o_to) begin
        n_bad++;
        $display("FAIL rnd_err t=%0d wr=%b f3=%0d a=%h got %b want %b to=%b", t, wr, f3, a, o_er, e_er, o_to);
      end
      n_cmp++;
      if (o_rd !== e_rd || o_lat !== e_lat || o_stable !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd_resp t=%0d wr=%b f3=%0d a=%h got rd=%h lat=%0d st=%b want rd=%h lat=%0d st=1",
                 t, wr, f3, a, o_rd, o_lat, o_stable, e_rd, e_lat);
      end
      n_cmp++;
      if (o_nwe !== ((e_er == 2'b00 && wr) ? 1 : 0) || o_nre !== ((e_er == 2'b00 && !wr) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL rnd_enables t=%0d got we=%0d re=%0d want err=%b wr=%b", t, o_nwe, o_nre, e_er, wr);
      end
      if (e_er == 2'b00) begin
        n_cmp++;
        if (o_maddr !== a[AW+1:2] ||
            (wr && (o_mask !== exp_mask(f3, a) || o_data !== exp_lanes(f3, wd)))) begin
          n_bad++;
          $display("FAIL rnd_bus t=%0d got a=%0d m=%b d=%h want a=%0d m=%b d=%h",
                   t, o_maddr, o_mask, o_data, a[AW+1:2], exp_mask(f3, a), exp_lanes(f3, wd));
        end
        if (wr) ref_store(f3, a, wd);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) env_mem[i] = 32'h0;
    for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    test_reset();
    test_store_word();
    test_load_extend();
    test_store_byte();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
